// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx
//
// Per-lane receive deserializer. Shifts in one serial bit per clk_32f edge, hunts
// bit-by-bit for the COM idle word, and locks after LOCK_COUNT consecutive
// word-aligned COM words. Once locked, every completed word is presented on lane_out
// with a level valid that is held for one full word period (32 cycles). COM words
// seen while locked are idles: they clear lane_out and valid_out.
//
// Ports:
//   clk_32f    in   serial bit clock, all logic on posedge
//   reset      in   asynchronous active-high reset
//   data_in    in   serial data, MSB of each word first
//   lane_out   out  [31:0] last completed data word (registered)
//   valid_out  out  lane_out holds a data word (registered level)
//   active_out out  high while locked
module serial_to_parallel_rx #(
  parameter logic [31:0] COM_WORD   = 32'hBCBCBCBC,
  parameter int unsigned LOCK_COUNT = 4  // 1..15
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] lane_out,
  output logic        valid_out,
  output logic        active_out
);

  typedef enum logic [1:0] {StHunt, StAlign, StLocked} state_e;

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  state_e      state_q;
  // Only the 31 most recent bits are kept; the oldest bit of the window never
  // participates in a comparison once the current bit is appended.
  logic [30:0] shreg_q;
  logic [4:0]  bit_cnt_q;
  logic [3:0]  com_cnt_q;

  logic [31:0] nxt;
  logic        is_com;
  logic        boundary;
  logic [3:0]  com_cnt_inc;

  // 32-bit window ending with the bit sampled on this edge.
  assign nxt         = {shreg_q, data_in};
  assign is_com      = (nxt == COM_WORD);
  assign boundary    = (bit_cnt_q == 5'd31);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q    <= StHunt;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      lane_out   <= '0;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      shreg_q   <= nxt[30:0];
      // Free-running word counter; in HUNT its value is irrelevant.
      bit_cnt_q <= bit_cnt_q + 5'd1;

      case (state_q)
        StHunt: begin
          if (is_com) begin
            // This edge becomes a word boundary: the next word ends 32 edges later.
            bit_cnt_q <= '0;
            com_cnt_q <= 4'd1;
            if (LockCnt == 4'd1) begin
              state_q    <= StLocked;
              active_out <= 1'b1;
            end else begin
              state_q <= StAlign;
            end
          end
        end

        StAlign: begin
          if (boundary) begin
            if (is_com) begin
              if (com_cnt_inc >= LockCnt) begin
                // bit_cnt wraps 31->0 naturally, keeping the established alignment.
                state_q    <= StLocked;
                active_out <= 1'b1;
                com_cnt_q  <= LockCnt;
              end else begin
                com_cnt_q <= com_cnt_inc;
              end
            end else begin
              // Misaligned or broken run: restart the search from the next edge.
              state_q   <= StHunt;
              com_cnt_q <= '0;
            end
          end
        end

        StLocked: begin
          // No loss-of-lock detection; only reset leaves this state.
          if (boundary) begin
            if (is_com) begin
              lane_out  <= '0;
              valid_out <= 1'b0;
            end else begin
              lane_out  <= nxt;
              valid_out <= 1'b1;
            end
          end
        end

        default: begin
          state_q   <= StHunt;
          com_cnt_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
module tb_serial_to_parallel_rx;

  localparam logic [31:0] Com = 32'hBCBCBCBC;

  logic        clk_32f;
  logic        reset;
  logic        data_in;
  logic [31:0] lane_out;
  logic        valid_out;
  logic        active_out;

  int n_vec;
  int n_err;

  // Expected {lane_out, valid_out, active_out} at each word boundary.
  logic [33:0] exp_q[$];
  // Value the outputs must hold between boundaries.
  logic [33:0] held;

  serial_to_parallel_rx #(
    .COM_WORD  (Com),
    .LOCK_COUNT(4)
  ) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .lane_out  (lane_out),
    .valid_out (valid_out),
    .active_out(active_out)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // Drive one bit away from the active edge; return 1 time unit after it is sampled.
  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    exp_q.delete();
    held = '0;
  endtask

  // mode 0: not locked at this word's end; 1: lock is declared at its end;
  // 2: already locked, the word is delivered (or idles the lane if COM).
  task automatic send_word(input logic [31:0] w, input int mode);
    logic [33:0] got;
    logic [33:0] exp_pop;
    if (mode == 2) begin
      if (w == Com) exp_q.push_back({32'h0, 1'b0, 1'b1});
      else          exp_q.push_back({w, 1'b1, 1'b1});
    end else if (mode == 1) begin
      exp_q.push_back({32'h0, 1'b0, 1'b1});
    end else begin
      exp_q.push_back({32'h0, 1'b0, 1'b0});
    end
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i]);
      got = {lane_out, valid_out, active_out};
      n_vec++;
      if (i > 0) begin
        if (got !== held) begin
          n_err++;
          $display("FAIL hold word=%h bit=%0d: got %h required %h", w, i, got, held);
        end
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard empty word=%h: got %h required an entry", w, got);
      end else begin
        exp_pop = exp_q.pop_front();
        if (got !== exp_pop) begin
          n_err++;
          $display("FAIL boundary word=%h: got %h required %h", w, got, exp_pop);
        end
        held = exp_pop;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_32f);
      data_in = ~data_in;
      @(posedge clk_32f);
      #1;
      n_vec++;
      if ({lane_out, valid_out, active_out} !== 34'h0) begin
        n_err++;
        $display("FAIL reset cycle %0d: got %h required 0", i, {lane_out, valid_out, active_out});
      end
    end
    @(negedge clk_32f);
    reset = 1'b0;
    exp_q.delete();
    held = '0;
  endtask

  task automatic test_lock_odd_offset();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      n_vec++;
      if ({lane_out, valid_out, active_out} !== 34'h0) begin
        n_err++;
        $display("FAIL lead bits %0d: got %h required 0", i, {lane_out, valid_out, active_out});
      end
    end
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(Com, 1);
    send_word(32'hDEADBEEF, 2);
  endtask

  task automatic test_idle_in_lock();
    // Continues from the locked state left by test_lock_odd_offset.
    send_word(Com, 2);
    send_word(32'h12345678, 2);
    send_word(32'h0000FFFF, 2);
    send_word(Com, 2);
  endtask

  task automatic test_aborted_lock();
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(32'h00000000, 0);
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(Com, 1);
    send_word(32'hA5A5A5A5, 2);
  endtask

  task automatic test_false_match();
    apply_reset();
    for (int i = 0; i < 8; i++) send_word(32'h00BCBC00, 0);
    // Must still need exactly four full COM words.
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(Com, 1);
    send_word(32'h00BCBC00, 2);
  endtask

  task automatic test_reset_mid_locked();
    logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(Com, 1);
    send_word(32'hDEADBEEF, 2);
    w = 32'hCAFEF00D;
    for (int i = 31; i >= 15; i--) begin
      send_bit(w[i]);
      n_vec++;
      if ({lane_out, valid_out, active_out} !== held) begin
        n_err++;
        $display("FAIL partial word bit %0d: got %h required %h", i,
                 {lane_out, valid_out, active_out}, held);
      end
    end
    // Assert reset between edges: outputs must clear without a clock.
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({lane_out, valid_out, active_out} !== 34'h0) begin
      n_err++;
      $display("FAIL async reset: got %h required 0", {lane_out, valid_out, active_out});
    end
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b0;
    exp_q.delete();
    held = '0;
    for (int i = 0; i < 3; i++) send_word(Com, 0);
    send_word(Com, 1);
    send_word(32'h0BADF00D, 2);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    held    = '0;
    reset   = 1'b1;
    data_in = 1'b0;
    test_reset();
    test_lock_odd_offset();
    test_idle_in_lock();
    test_aborted_lock();
    test_false_match();
    test_reset_mid_locked();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard leftover: got %0d entries required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Per-lane receive deserializer. Converts the 1-bit serial stream of one PHY lane into 32-bit words.
- Acquires word alignment by hunting for the COM idle word, then locks.
- Emits words with a level-valid held for one full word period. This is the lane_N/valid_N format consumed by the byte unstriping stage.
- One instance per lane, clocked at the serial bit rate.

Parameters:
- COM_WORD, 32'hBCBCBCBC, idle/alignment word; never forwarded as data.
- LOCK_COUNT, 4, consecutive word-aligned COM words required to declare lock (range 1..15).

Ports:
- clk_32f  input  1  serial bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  1  serial data, MSB of each word first, sampled on posedge clk_32f.
- lane_out  output  32  last completed data word (registered).
- valid_out  output  1  lane_out holds a data word (registered level, not a pulse).
- active_out  output  1  high while in LOCKED.

Behaviour:
Reset:
- While reset is high: shift register = 0, bit_cnt = 0, com_cnt = 0, state = HUNT, lane_out = 32'h0, valid_out = 0, active_out = 0.
- Outputs clear asynchronously on reset assertion.
- The first sample is taken on the first posedge after reset deasserts.

Datapath:
- Every posedge: shreg <= {shreg[30:0], data_in}.
- nxt = {shreg[30:0], data_in} is the 32-bit window ending with the current bit.

Word boundary:
- bit_cnt is a 5-bit counter (0..31) that wraps at 31->0.
- A word completes on the edge where bit_cnt == 31; that word is nxt.

State HUNT:
- bit_cnt is don't-care.
- Each edge: if nxt == COM_WORD -> ALIGN, com_cnt = 1, bit_cnt = 0 (that edge is treated as a boundary).
- Otherwise stay in HUNT.
- Bit-by-bit search; any bit offset is found.
- If LOCK_COUNT == 1, go directly to LOCKED instead of ALIGN.

State ALIGN:
- bit_cnt increments every edge.
- At each boundary:
  - nxt == COM_WORD: com_cnt + 1. If that reaches LOCK_COUNT -> LOCKED, bit_cnt wraps to 0.
  - nxt != COM_WORD: -> HUNT, com_cnt = 0.
- The hunt does not re-check the current edge.

State LOCKED:
- active_out = 1 (registered, asserted on the transition edge).
- bit_cnt continues free-running.
- At each boundary:
  - nxt != COM_WORD: lane_out <= nxt, valid_out <= 1.
  - nxt == COM_WORD: lane_out <= 0, valid_out <= 0.
- Between boundaries lane_out and valid_out hold, so each word is stable for exactly 32 cycles.
- Latency: the word's last bit sampled at edge k appears on lane_out after edge k.
- Lock is left only via reset. No loss-of-lock detection in this block.

Outputs outside LOCKED:
- valid_out = 0, lane_out = 0, active_out = 0 in HUNT and ALIGN.

Boundary conditions:
- COM pattern straddling garbage (e.g. 16 bits of 0xBC bytes at a wrong offset) must not trigger.
- Only the full 32-bit match counts.
- The first lock attempt may land on an offset that is a multiple of 8 bits inside a COM run. This is harmless: all shifted views of COM_WORD equal COM_WORD.
- Reset asserted mid-word in any state: immediate return to reset values; a partial word is discarded.
- Counters: com_cnt saturates at LOCK_COUNT; no overflow.

Test Plan:
- Reset: hold reset 3 cycles with data_in toggling -> lane_out = 0, valid_out = 0, active_out = 0 throughout; state HUNT after release.
- Lock at odd offset: 5 random bits, then 4 x 32'hBCBCBCBC -> active_out rises on the edge of the 128th COM bit. Then 32'hDEADBEEF -> lane_out = 32'hDEADBEEF and valid_out = 1 after its 32nd bit, held exactly 32 cycles.
- Idle in lock: after DEADBEEF send COM then 32'h12345678 -> valid_out = 0 and lane_out = 0 for 32 cycles, then lane_out = 32'h12345678 with valid_out = 1.
- Aborted lock: 3 COM words then 32'h00000000, then 4 COM words -> active_out stays 0 until the end of the 4 later COM words; no valid_out during the first sequence.
- False match rejection: stream 32'h00BCBC00 repeated for 256 cycles -> stays in HUNT, active_out = 0.
- Reset mid-LOCKED: assert reset at bit 17 of a data word -> outputs clear immediately. After release, relock requires 4 fresh COM words.
